// File: rtl/romem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : romem_arbiter_if
//  Description : Bundle of the requester-side and ROM-side signals of the
//                romem_arbiter. The arbiter connects via the 'slave' modport.
//                The surrounding system (fetch path, debug/loader path and
//                ROM) connects via the 'master' modport.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WORD_SIZE       bits per ROM word and per address
//  Signals (directions seen from the arbiter)
//    req0/req1       in   request from port 0 / port 1, held until resp
//    addr0/addr1     in   word address, stable while the matching req is high
//    gnt0/gnt1       out  one-cycle accept pulse
//    resp0/resp1     out  one-cycle response pulse
//    rdata           out  {word A+1, word A}; valid while a resp pulse is high
//    err             out  qualifies the resp pulse as an error (rdata = 0)
//    rom_enable      out  ROM ENABLE
//    rom_address     out  ROM ADDRESS
//    rom_data_ready  in   ROM DATA_READY
//    rom_data        in   ROM DATA (two words)
// ============================================================================
interface romem_arbiter_if #(
  parameter int WORD_SIZE = 32
);
  logic                     req0;
  logic                     req1;
  logic [WORD_SIZE-1:0]     addr0;
  logic [WORD_SIZE-1:0]     addr1;
  logic                     gnt0;
  logic                     gnt1;
  logic                     resp0;
  logic                     resp1;
  logic [2*WORD_SIZE-1:0]   rdata;
  logic                     err;
  logic                     rom_enable;
  logic [WORD_SIZE-1:0]     rom_address;
  logic                     rom_data_ready;
  logic [2*WORD_SIZE-1:0]   rom_data;

  // Arbiter side.
  modport slave (
    input  req0, req1, addr0, addr1, rom_data_ready, rom_data,
    output gnt0, gnt1, resp0, resp1, rdata, err, rom_enable, rom_address
  );

  // System side: requesters plus the ROM itself.
  modport master (
    output req0, req1, addr0, addr1, rom_data_ready, rom_data,
    input  gnt0, gnt1, resp0, resp1, rdata, err, rom_enable, rom_address
  );
endinterface
`default_nettype wire

// File: rtl/romem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : romem_arbiter
//  Description : Two-port arbiter and transaction sequencer in front of the
//                read-only instruction memory. Port 0 is instruction fetch.
//                Port 1 is a secondary read-only path, such as debug or
//                loader. One ROM transaction runs at a time. Each transaction
//                returns the two-word line {mem[A+1], mem[A]} or an error to
//                the port that was granted.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WORD_SIZE   bits per ROM word and per address          (default 32)
//    ENTRIES     number of ROM words; valid addresses are
//                0..ENTRIES-2                              (default 128)
//    TIMEOUT     BUSY-cycle limit per ROM transaction;
//                present only when ROMEM_ARB_TIMEOUT_EN is
//                defined                                   (default 16)
//  Ports
//    Clk         clock, rising edge
//    Rst         synchronous, active-high reset
//    bus         romem_arbiter_if.slave: requester handshakes and ROM port
//  Build option
//    ROMEM_ARB_TIMEOUT_EN  When defined, BUSY aborts with err=1 after
//                          TIMEOUT cycles without DATA_READY. When undefined,
//                          BUSY waits for DATA_READY indefinitely.
//  Timing (request sampled in IDLE at edge E)
//    E+1 : gnt pulse, rom_enable high, rom_address = latched address
//    BUSY holds until DATA_READY is sampled, then DONE (rom_enable low)
//    resp/err/rdata are registered at the edge that leaves DONE, and a new
//    grant may be issued at that same edge.
// ============================================================================
module romem_arbiter #(
  parameter int WORD_SIZE = 32,
  parameter int ENTRIES   = 128
`ifdef ROMEM_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT   = 16
`endif
) (
  input  logic            Clk,
  input  logic            Rst,
  romem_arbiter_if.slave  bus
);

  // Highest legal word address. Every access also reads word A+1.
  localparam logic [WORD_SIZE-1:0] c_MAX_ADDR = WORD_SIZE'(ENTRIES - 2);

`ifdef ROMEM_ARB_TIMEOUT_EN
  localparam int                   c_TMO_W    = $clog2(TIMEOUT + 1);
  // The counter is 0 in the first BUSY cycle. Aborting when it reads
  // TIMEOUT-1 therefore gives exactly TIMEOUT BUSY cycles.
  localparam logic [c_TMO_W-1:0]   c_TMO_LAST = c_TMO_W'(TIMEOUT - 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  r_state;
  logic                    r_gnt0;
  logic                    r_gnt1;
  logic                    r_resp0;
  logic                    r_resp1;
  logic                    r_err;
  logic [2*WORD_SIZE-1:0]  r_rdata;
  logic                    r_rom_enable;
  logic [WORD_SIZE-1:0]    r_rom_address;
  logic                    r_last_served;  // port granted most recently
  logic                    r_port;         // port owning the transaction
  logic                    r_fail;         // transaction ends with err
  logic [2*WORD_SIZE-1:0]  r_line;         // captured ROM line (0 on error)
`ifdef ROMEM_ARB_TIMEOUT_EN
  logic [c_TMO_W-1:0]      r_tmo_cnt;
`endif

  logic                    w_any_req;
  logic                    w_pick1;
  logic [WORD_SIZE-1:0]    w_sel_addr;
  logic                    w_addr_bad;

  // Arbitration. A lone request always wins. On a tie, the port opposite
  // to the last served port wins. The two ports therefore alternate under
  // continuous contention.
  assign w_any_req  = bus.req0 | bus.req1;
  assign w_pick1    = bus.req1 & (~bus.req0 | ~r_last_served);
  assign w_sel_addr = w_pick1 ? bus.addr1 : bus.addr0;
  assign w_addr_bad = (w_sel_addr > c_MAX_ADDR);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state       <= S_IDLE;
      r_gnt0        <= 1'b0;
      r_gnt1        <= 1'b0;
      r_resp0       <= 1'b0;
      r_resp1       <= 1'b0;
      r_err         <= 1'b0;
      r_rdata       <= '0;
      r_rom_enable  <= 1'b0;
      r_rom_address <= '0;
      r_last_served <= 1'b1;
      r_port        <= 1'b0;
      r_fail        <= 1'b0;
      r_line        <= '0;
`ifdef ROMEM_ARB_TIMEOUT_EN
      r_tmo_cnt     <= '0;
`endif
    end else begin
      // Pulse outputs default low. They are raised for one cycle only.
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_resp0 <= 1'b0;
      r_resp1 <= 1'b0;
      r_err   <= 1'b0;

      unique case (r_state)
        S_BUSY: begin
          // rom_enable and rom_address stay unchanged until the ROM answers.
          // A ready on the same edge as the timeout takes precedence.
          if (bus.rom_data_ready) begin
            r_line       <= bus.rom_data;
            r_fail       <= 1'b0;
            r_rom_enable <= 1'b0;
            r_state      <= S_DONE;
          end
`ifdef ROMEM_ARB_TIMEOUT_EN
          else if (r_tmo_cnt == c_TMO_LAST) begin
            r_line       <= '0;
            r_fail       <= 1'b1;
            r_rom_enable <= 1'b0;
            r_state      <= S_DONE;
          end else begin
            r_tmo_cnt    <= r_tmo_cnt + 1'b1;
          end
`endif
        end

        S_IDLE, S_DONE: begin
          // Leaving DONE issues the response for the finished transaction.
          if (r_state == S_DONE) begin
            r_resp0 <= ~r_port;
            r_resp1 <= r_port;
            r_err   <= r_fail;
            r_rdata <= r_line;
          end

          // rom_enable is low for at least this one cycle between accesses.
          // The ROM uses that low cycle to restart its delay counter.
          r_rom_enable <= 1'b0;

          if (w_any_req) begin
            r_gnt0        <= ~w_pick1;
            r_gnt1        <= w_pick1;
            r_port        <= w_pick1;
            r_last_served <= w_pick1;
            if (w_addr_bad) begin
              // The line would run past the array. Skip the ROM entirely.
              r_line  <= '0;
              r_fail  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_rom_address <= w_sel_addr;
              r_rom_enable  <= 1'b1;
              r_state       <= S_BUSY;
`ifdef ROMEM_ARB_TIMEOUT_EN
              r_tmo_cnt     <= '0;
`endif
            end
          end else begin
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_rom_enable <= 1'b0;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt0        = r_gnt0;
  assign bus.gnt1        = r_gnt1;
  assign bus.resp0       = r_resp0;
  assign bus.resp1       = r_resp1;
  assign bus.err         = r_err;
  assign bus.rdata       = r_rdata;
  assign bus.rom_enable  = r_rom_enable;
  assign bus.rom_address = r_rom_address;

endmodule
`default_nettype wire

// File: tb/tb_romem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_romem_arbiter
//  Description : Directed, self-checking bench for romem_arbiter. It contains
//                a behavioural ROM with DATA_DELAY=2. Enable rises at edge E.
//                Ready is then raised at E+2 and sampled by the arbiter at
//                E+3. The ROM can be stalled so that ready never comes.
//                All checks are made 1 time unit after a rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_romem_arbiter;

  localparam int WS         = 32;
  localparam int DATA_DELAY = 2;

  logic Clk;
  logic Rst;
  int   vectors;
  int   miscompares;
  logic rom_stall;
  int   rom_cnt;

  romem_arbiter_if #(.WORD_SIZE(WS)) bus ();

  romem_arbiter #(
    .WORD_SIZE (WS),
    .ENTRIES   (128)
  ) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ROM contents: an arbitrary, address-dependent pattern.
  function automatic logic [WS-1:0] mem_word(input logic [WS-1:0] a);
    return 32'hC0DE_0000 ^ (a * 32'h0001_0003);
  endfunction

  function automatic logic [2*WS-1:0] line(input logic [WS-1:0] a);
    return {mem_word(a + 1), mem_word(a)};
  endfunction

  // Behavioural ROM. The counter restarts whenever enable is low.
  always @(posedge Clk) begin
    if (Rst || !bus.rom_enable) begin
      rom_cnt            <= 0;
      bus.rom_data_ready <= 1'b0;
      bus.rom_data       <= '0;
    end else begin
      rom_cnt <= rom_cnt + 1;
      if (rom_cnt == DATA_DELAY - 1 && !rom_stall) begin
        bus.rom_data_ready <= 1'b1;
        bus.rom_data       <= line(bus.rom_address);
      end
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  int resp_seen;

  initial begin
    vectors     = 0;
    miscompares = 0;
    rom_stall   = 1'b0;
    Rst         = 1'b1;
    bus.req0    = 1'b0;
    bus.req1    = 1'b0;
    bus.addr0   = '0;
    bus.addr1   = '0;

    // ---------------- reset values ----------------
    tick(2);
    chk("rst_gnt",   {bus.gnt0, bus.gnt1},   2'b00);
    chk("rst_resp",  {bus.resp0, bus.resp1}, 2'b00);
    chk("rst_err",   bus.err,                1'b0);
    chk("rst_rdata", bus.rdata,              64'h0);
    chk("rst_en",    bus.rom_enable,         1'b0);
    chk("rst_addr",  bus.rom_address,        32'h0);
    Rst = 1'b0;
    tick();

    // ---------------- single req0, addr 0x10 ----------------
    // The requester drops req after its grant. The transaction must still
    // run to completion.
    bus.req0 = 1'b1; bus.addr0 = 32'h10;
    tick();                                           // +1
    chk("a_gnt", {bus.gnt0, bus.gnt1}, 2'b10);
    chk("a_en1", bus.rom_enable, 1'b1);
    chk("a_adr", bus.rom_address, 32'h10);
    bus.req0 = 1'b0;
    tick();                                           // +2
    chk("a_gnt_pulse", bus.gnt0, 1'b0);
    chk("a_en2", bus.rom_enable, 1'b1);
    tick();                                           // +3
    chk("a_en3", bus.rom_enable, 1'b1);
    tick();                                           // +4 DONE
    chk("a_en4", bus.rom_enable, 1'b0);
    chk("a_noresp4", bus.resp0, 1'b0);
    tick();                                           // +5
    chk("a_resp", {bus.resp0, bus.resp1, bus.err}, 3'b100);
    chk("a_rdata", bus.rdata, line(32'h10));
    tick();
    chk("a_resp_pulse", bus.resp0, 1'b0);

    // ---------------- out-of-range address on port 1 ----------------
    bus.req1 = 1'b1; bus.addr1 = 32'd127;
    tick();                                           // +1
    chk("e_gnt", {bus.gnt0, bus.gnt1}, 2'b01);
    chk("e_en1", bus.rom_enable, 1'b0);
    bus.req1 = 1'b0;
    tick();                                           // +2
    chk("e_resp", {bus.resp0, bus.resp1, bus.err}, 3'b011);
    chk("e_rdata", bus.rdata, 64'h0);
    chk("e_en2", bus.rom_enable, 1'b0);
    tick();
    chk("e_clear", {bus.resp1, bus.err}, 2'b00);

    // ---------------- back-to-back on port 0 ----------------
    bus.req0 = 1'b1; bus.addr0 = 32'h05;
    tick();                                           // +1
    chk("b_gnt1", bus.gnt0, 1'b1);
    tick(2);                                          // +3
    chk("b_en3", bus.rom_enable, 1'b1);
    // The first address is already latched. The next request (0x40) is
    // presented while req stays high.
    bus.addr0 = 32'h40;
    tick();                                           // +4 DONE
    chk("b_en_gap", bus.rom_enable, 1'b0);
    tick();                                           // +5
    chk("b_regnt", {bus.gnt0, bus.resp0}, 2'b11);
    chk("b_rdata1", bus.rdata, line(32'h05));
    chk("b_en5", bus.rom_enable, 1'b1);
    chk("b_adr2", bus.rom_address, 32'h40);
    bus.req0 = 1'b0;
    tick(3);                                          // +8 DONE
    chk("b_en8", bus.rom_enable, 1'b0);
    tick();                                           // +9
    chk("b_resp2", {bus.resp0, bus.err}, 2'b10);
    chk("b_rdata2", bus.rdata, line(32'h40));

    // ---------------- reset held 2 cycles mid-BUSY ----------------
    bus.req0 = 1'b1; bus.addr0 = 32'h22;
    tick();
    chk("r_gnt", bus.gnt0, 1'b1);
    bus.req0 = 1'b0;
    tick();                                           // in BUSY
    Rst = 1'b1;
    tick();
    chk("r_en", bus.rom_enable, 1'b0);
    chk("r_outs", {bus.gnt0, bus.gnt1, bus.resp0, bus.resp1, bus.err}, 5'b0);
    chk("r_rdata", bus.rdata, 64'h0);
    chk("r_adr", bus.rom_address, 32'h0);
    tick();
    chk("r_hold", {bus.rom_enable, bus.resp0}, 2'b00);
    Rst = 1'b0;
    tick();
    chk("r_noresp", bus.resp0, 1'b0);
    bus.req0 = 1'b1; bus.addr0 = 32'h4;
    tick();
    chk("r_regnt", {bus.gnt0, bus.rom_enable}, 2'b11);
    bus.req0 = 1'b0;
    tick(4);
    chk("r_resp", {bus.resp0, bus.err}, 2'b10);
    chk("r_rdata4", bus.rdata, line(32'h4));

    // ---------------- both ports held, first after reset ----------------
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    bus.req0 = 1'b1; bus.addr0 = 32'h20;
    bus.req1 = 1'b1; bus.addr1 = 32'h30;
    tick();                                           // +1
    chk("t_g1", {bus.gnt0, bus.gnt1}, 2'b10);
    tick(4);                                          // +5
    chk("t_g2", {bus.gnt0, bus.gnt1}, 2'b01);
    chk("t_r1", {bus.resp0, bus.resp1}, 2'b10);
    chk("t_d1", bus.rdata, line(32'h20));
    tick(4);                                          // +9
    chk("t_g3", {bus.gnt0, bus.gnt1}, 2'b10);
    chk("t_r2", {bus.resp0, bus.resp1}, 2'b01);
    chk("t_d2", bus.rdata, line(32'h30));
    tick(4);                                          // +13
    chk("t_g4", {bus.gnt0, bus.gnt1}, 2'b01);
    chk("t_r3", {bus.resp0, bus.resp1}, 2'b10);
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    tick(4);                                          // +17
    chk("t_r4", {bus.resp0, bus.resp1, bus.gnt0, bus.gnt1}, 4'b0100);
    chk("t_d4", bus.rdata, line(32'h30));

    // ---------------- ROM that never answers ----------------
    rom_stall = 1'b1;
    bus.req0 = 1'b1; bus.addr0 = 32'h08;
    tick();                                           // +1
    chk("s_gnt", {bus.gnt0, bus.rom_enable}, 2'b11);
    bus.req0 = 1'b0;
`ifdef ROMEM_ARB_TIMEOUT_EN
    tick(15);                                         // +16, last BUSY cycle
    chk("s_en16", {bus.rom_enable, bus.resp0}, 2'b10);
    tick();                                           // +17 DONE
    chk("s_en17", {bus.rom_enable, bus.resp0}, 2'b00);
    tick();                                           // +18
    chk("s_resp", {bus.resp0, bus.err}, 2'b11);
    chk("s_rdata", bus.rdata, 64'h0);
`else
    resp_seen = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (bus.resp0 || bus.resp1) resp_seen++;
    end
    chk("s_noresp", resp_seen, 0);
    chk("s_en", bus.rom_enable, 1'b1);
`endif
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    rom_stall = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
